// File: rtl/mem_client_if.sv
// mem_client_if: bundle of the command, response and memory-device signals of mem_client.
// Optional feature macro: MEM_CLIENT_BURST_EN (adds req_len).
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_wdata[/req_len]  local command handshake
//   rsp_valid/rsp_rdata/rsp_last/rsp_err                     per-beat response
//   mem_en/mem_we/mem_burst_en/mem_addr/mem_di               request lines to the controller
//   mem_do_ack/mem_do                                        ack bit and shared read data
// Modports:
//   slave  - the mem_client itself
//   master - the environment (command source and memory controller)
interface mem_client_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
`ifdef MEM_CLIENT_BURST_EN
  logic [1:0]  req_len;
`endif
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_last;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic        mem_burst_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_di;
  logic        mem_do_ack;
  logic [31:0] mem_do;

`ifdef MEM_CLIENT_BURST_EN
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_len, mem_do_ack, mem_do,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
    output mem_en, mem_we, mem_burst_en, mem_addr, mem_di
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_len, mem_do_ack, mem_do,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
    input  mem_en, mem_we, mem_burst_en, mem_addr, mem_di
  );
`else
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_do_ack, mem_do,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
    output mem_en, mem_we, mem_burst_en, mem_addr, mem_di
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_do_ack, mem_do,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
    input  mem_en, mem_we, mem_burst_en, mem_addr, mem_di
  );
`endif
endinterface

// File: rtl/mem_client.sv
// mem_client: single-outstanding memory request client.
// Accepts a local read/write command, presents it to the memory controller and holds it until
// the controller acks or the ack timeout expires, then returns one response per beat.
// Optional feature macro: MEM_CLIENT_BURST_EN -- multi-beat reads via req_len/mem_burst_en.
// Ports:
//   i_clk    - single clock, rising edge
//   i_reset  - asynchronous active-high reset
//   io_bus   - mem_client_if.slave: req_* command in, rsp_* response out, mem_* device side
// Parameters:
//   ACK_TIMEOUT - REQ cycles without ack before abort; 0 disables the timeout
module mem_client #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input logic         i_clk,
  input logic         i_reset,
  mem_client_if.slave io_bus
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01
  } state_e;

  state_e      r_state, w_state;
  logic        r_mem_en, w_mem_en;
  logic        r_mem_we, w_mem_we;
  logic        r_burst, w_burst;
  logic [9:0]  r_mem_addr, w_mem_addr;
  logic [31:0] r_mem_di, w_mem_di;
  logic        r_rsp_valid, w_rsp_valid;
  logic [31:0] r_rsp_rdata, w_rsp_rdata;
  logic        r_rsp_last, w_rsp_last;
  logic        r_rsp_err, w_rsp_err;
  logic [7:0]  r_tmo_cnt, w_tmo_cnt;
  logic [1:0]  r_beats, w_beats;  // beats still to run after the current one
  logic [1:0]  w_len;
  logic        w_tmo_hit;

`ifdef MEM_CLIENT_BURST_EN
  assign w_len = io_bus.req_len;
`else
  // Without bursts every transaction is one beat, so r_burst never leaves 0.
  assign w_len = 2'b00;
`endif

  // This cycle is the last one allowed without an ack.
  assign w_tmo_hit = (ACK_TIMEOUT != 0) && ((32'(r_tmo_cnt) + 32'd1) >= ACK_TIMEOUT);

  always_comb begin
    w_state     = r_state;
    w_mem_en    = r_mem_en;
    w_mem_we    = r_mem_we;
    w_burst     = r_burst;
    w_mem_addr  = r_mem_addr;
    w_mem_di    = r_mem_di;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = 32'd0;
    w_rsp_last  = 1'b0;
    w_rsp_err   = 1'b0;
    w_tmo_cnt   = r_tmo_cnt;
    w_beats     = r_beats;
    case (r_state)
      StIdle: begin
        if (io_bus.req_valid) begin
          w_state    = StReq;
          w_mem_en   = 1'b1;
          w_mem_we   = io_bus.req_we;
          w_mem_addr = io_bus.req_addr;
          w_mem_di   = io_bus.req_wdata;
          w_tmo_cnt  = 8'd0;
          // Writes are always single-beat.
          w_beats    = io_bus.req_we ? 2'd0 : w_len;
          w_burst    = !io_bus.req_we && (w_len != 2'd0);
        end
      end
      StReq: begin
        if (io_bus.mem_do_ack) begin
          // Ack beats a coincident timeout.
          w_tmo_cnt   = 8'd0;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_mem_we ? 32'd0 : io_bus.mem_do;
          if (r_beats != 2'd0) begin
            w_beats    = r_beats - 2'd1;
            w_mem_addr = r_mem_addr + 10'd4;
            w_burst    = (r_beats > 2'd1);
          end else begin
            w_state    = StIdle;
            w_mem_en   = 1'b0;
            w_mem_we   = 1'b0;
            w_burst    = 1'b0;
            w_rsp_last = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_state     = StIdle;
          w_mem_en    = 1'b0;
          w_mem_we    = 1'b0;
          w_burst     = 1'b0;
          w_beats     = 2'd0;
          w_tmo_cnt   = 8'd0;
          w_rsp_valid = 1'b1;
          w_rsp_last  = 1'b1;
          w_rsp_err   = 1'b1;
        end else begin
          w_tmo_cnt = r_tmo_cnt + 8'd1;
        end
      end
      default: begin
        w_state  = StIdle;
        w_mem_en = 1'b0;
        w_mem_we = 1'b0;
        w_burst  = 1'b0;
        w_beats  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_burst     <= 1'b0;
      r_mem_addr  <= 10'd0;
      r_mem_di    <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_tmo_cnt   <= 8'd0;
      r_beats     <= 2'd0;
    end else begin
      r_state     <= w_state;
      r_mem_en    <= w_mem_en;
      r_mem_we    <= w_mem_we;
      r_burst     <= w_burst;
      r_mem_addr  <= w_mem_addr;
      r_mem_di    <= w_mem_di;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_last  <= w_rsp_last;
      r_rsp_err   <= w_rsp_err;
      r_tmo_cnt   <= w_tmo_cnt;
      r_beats     <= w_beats;
    end
  end

  assign io_bus.req_ready    = (r_state == StIdle);
  assign io_bus.rsp_valid    = r_rsp_valid;
  assign io_bus.rsp_rdata    = r_rsp_rdata;
  assign io_bus.rsp_last     = r_rsp_last;
  assign io_bus.rsp_err      = r_rsp_err;
  assign io_bus.mem_en       = r_mem_en;
  assign io_bus.mem_we       = r_mem_we;
  assign io_bus.mem_burst_en = r_burst;
  assign io_bus.mem_addr     = r_mem_addr;
  assign io_bus.mem_di       = r_mem_di;

endmodule

// File: tb/tb_mem_client.sv
// tb_mem_client: self-checking bench for mem_client (ACK_TIMEOUT = 4).
// Burst checks are compiled in when MEM_CLIENT_BURST_EN is defined.
module tb_mem_client;
  localparam int unsigned AckTo = 4;
`ifdef MEM_CLIENT_BURST_EN
  localparam bit BurstBuild = 1'b1;
`else
  localparam bit BurstBuild = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_client_if bus ();
  mem_client #(.ACK_TIMEOUT(AckTo)) dut (.i_clk(clk), .i_reset(rst), .io_bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Stimulus for one transaction: ack delay (REQ cycles before the ack cycle) and data per beat.
  int          dly[4];
  logic [31:0] dat[4];
  logic [1:0]  txn_len;

  // Observations gathered by run_txn.
  int          obs_n, obs_nack, obs_en_cyc;
  bit          obs_unstable, obs_hung;
  logic        obs_ready_at_req, obs_ready_at_last, obs_en_at_last;
  logic [31:0] obs_rdata[8];
  logic        obs_last[8], obs_err[8];
  logic [9:0]  obs_addr[4];
  logic        obs_we[4], obs_burst[4];
  logic [31:0] obs_di[4];

  // Reference expectations.
  int          exp_n, exp_nack, exp_en_cyc;
  logic [31:0] exp_rdata[4];
  logic        exp_last[4], exp_err[4], exp_burst[4];
  logic [9:0]  exp_addr[4];

  // Reference: a read runs len+1 beats (burst build), each at base+4*i modulo 1024; a beat
  // whose ack comes later than AckTo REQ cycles aborts the transaction with an error response.
  task automatic model_txn(input logic we, input logic [9:0] addr);
    int beats;
    bit stop;
    stop  = 1'b0;
    beats = (BurstBuild && !we) ? int'(txn_len) + 1 : 1;
    exp_n = 0; exp_nack = 0; exp_en_cyc = 0;
    for (int i = 0; i < beats && !stop; i++) begin
      exp_addr[i]  = addr + 10'(4 * i);
      exp_burst[i] = (beats - i) > 1;
      if (dly[i] >= int'(AckTo)) begin
        exp_rdata[i] = 32'd0; exp_last[i] = 1'b1; exp_err[i] = 1'b1;
        exp_en_cyc += int'(AckTo);
        stop = 1'b1;
      end else begin
        exp_rdata[i] = we ? 32'd0 : dat[i];
        exp_last[i] = (i == beats - 1); exp_err[i] = 1'b0;
        exp_en_cyc += dly[i] + 1;
        exp_nack++;
      end
      exp_n++;
    end
  endtask

  // Issue one command, play the memory controller from dly/dat, record what the DUT does.
  task automatic run_txn(input logic we, input logic [9:0] addr, input logic [31:0] wdata);
    int beat = 0;
    int cyc = 0;
    bit done = 1'b0;
    logic [9:0] a0 = '0;
    logic [31:0] d0 = '0;
    logic w0 = 1'b0;
    obs_n = 0; obs_nack = 0; obs_en_cyc = 0; obs_unstable = 1'b0; obs_hung = 1'b0;
    obs_en_at_last = 1'bx; obs_ready_at_last = 1'bx;
    @(negedge clk);
    obs_ready_at_req = bus.req_ready;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
`ifdef MEM_CLIENT_BURST_EN
    bus.req_len = txn_len;
`endif
    @(negedge clk);
    for (int t = 0; t < 200 && !done; t++) begin
      if (bus.mem_en === 1'b1) obs_en_cyc++;
      if (bus.rsp_valid === 1'b1) begin
        if (obs_n < 8) begin
          obs_rdata[obs_n] = bus.rsp_rdata;
          obs_last[obs_n] = bus.rsp_last;
          obs_err[obs_n] = bus.rsp_err;
        end
        obs_n++;
        if (bus.rsp_last === 1'b1) begin
          done = 1'b1;
          obs_en_at_last = bus.mem_en;
          obs_ready_at_last = bus.req_ready;
        end
      end
      if (done) begin
        bus.req_valid = 1'b0;
        bus.mem_do_ack = 1'b0;
      end else begin
        // Junk commands while busy must be ignored.
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_we = 1'($urandom_range(0, 1));
        bus.req_addr = 10'($urandom);
        bus.req_wdata = $urandom;
        if (cyc == 0) begin
          a0 = bus.mem_addr; d0 = bus.mem_di; w0 = bus.mem_we;
        end else if (bus.mem_addr !== a0 || bus.mem_di !== d0 || bus.mem_we !== w0) begin
          obs_unstable = 1'b1;
        end
        if (bus.mem_en !== 1'b1) obs_unstable = 1'b1;
        if (beat < 4 && cyc == dly[beat]) begin
          bus.mem_do_ack = 1'b1;
          bus.mem_do = dat[beat];
          obs_addr[beat] = bus.mem_addr; obs_we[beat] = bus.mem_we;
          obs_di[beat] = bus.mem_di; obs_burst[beat] = bus.mem_burst_en;
          obs_nack++; beat++; cyc = 0;
        end else begin
          bus.mem_do_ack = 1'b0;
          bus.mem_do = $urandom;
          cyc++;
        end
        @(negedge clk);
      end
    end
    bus.mem_do_ack = 1'b0;
    bus.req_valid = 1'b0;
    if (!done) obs_hung = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_do_ack = 1'b0; bus.mem_do = '0;
`ifdef MEM_CLIENT_BURST_EN
    bus.req_len = '0;
`endif
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.req_ready, bus.mem_en, bus.mem_we, bus.mem_burst_en, bus.rsp_valid, bus.rsp_last,
         bus.rsp_err} !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy/en/we/bu/v/l/e=%b%b%b%b%b%b%b want 1000000",
               bus.req_ready, bus.mem_en, bus.mem_we, bus.mem_burst_en, bus.rsp_valid,
               bus.rsp_last, bus.rsp_err);
    end
    n_vec++;
    if ({bus.mem_addr, bus.mem_di, bus.rsp_rdata} !== 74'd0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h di=%h rdata=%h want 0", bus.mem_addr, bus.mem_di,
               bus.rsp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 1'b1 || bus.mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got ready=%b en=%b want 1 0", bus.req_ready, bus.mem_en);
    end
  endtask

  task automatic test_single_read();
    dly[0] = 3; dat[0] = 32'hDEADBEEF; txn_len = 2'd0;
    run_txn(1'b0, 10'h010, $urandom);
    n_vec++;
    if (obs_hung || obs_n != 1) begin
      n_err++; $display("FAIL rd_count: got %0d hung=%0d want 1", obs_n, obs_hung);
    end
    n_vec++;
    if (obs_rdata[0] !== 32'hDEADBEEF || {obs_last[0], obs_err[0]} !== 2'b10) begin
      n_err++;
      $display("FAIL rd_rsp: got %h l=%b e=%b want deadbeef 1 0", obs_rdata[0], obs_last[0],
               obs_err[0]);
    end
    n_vec++;
    if (obs_addr[0] !== 10'h010 || obs_we[0] !== 1'b0 || obs_burst[0] !== 1'b0) begin
      n_err++;
      $display("FAIL rd_req: got addr=%h we=%b bu=%b want 010 0 0", obs_addr[0], obs_we[0],
               obs_burst[0]);
    end
    n_vec++;
    if (obs_en_at_last !== 1'b0 || obs_ready_at_last !== 1'b1 || obs_en_cyc != 4) begin
      n_err++;
      $display("FAIL rd_end: got en=%b ready=%b en_cycles=%0d want 0 1 4", obs_en_at_last,
               obs_ready_at_last, obs_en_cyc);
    end
  endtask

  task automatic test_single_write();
    dly[0] = 1; dat[0] = $urandom | 32'h1; txn_len = 2'd0;
    run_txn(1'b1, 10'h020, 32'h12345678);
    n_vec++;
    if (obs_hung || obs_n != 1 || obs_rdata[0] !== 32'd0 || obs_err[0] !== 1'b0) begin
      n_err++;
      $display("FAIL wr_rsp: got n=%0d rdata=%h e=%b want 1 0 0", obs_n, obs_rdata[0],
               obs_err[0]);
    end
    n_vec++;
    if (obs_we[0] !== 1'b1 || obs_di[0] !== 32'h12345678 || obs_addr[0] !== 10'h020 ||
        obs_unstable) begin
      n_err++;
      $display("FAIL wr_req: got we=%b di=%h addr=%h unstable=%0d want 1 12345678 020 0",
               obs_we[0], obs_di[0], obs_addr[0], obs_unstable);
    end
  endtask

  task automatic test_timeout();
    dly[0] = 99; dat[0] = $urandom; txn_len = 2'd0;
    run_txn(1'b0, 10'h0AA, $urandom);
    n_vec++;
    if (obs_hung || obs_n != 1 || obs_rdata[0] !== 32'd0 || {obs_last[0], obs_err[0]} !== 2'b11)
    begin
      n_err++;
      $display("FAIL tmo_rsp: got n=%0d rdata=%h l=%b e=%b want 1 0 1 1", obs_n, obs_rdata[0],
               obs_last[0], obs_err[0]);
    end
    n_vec++;
    if (obs_en_cyc != 4 || obs_ready_at_last !== 1'b1 || obs_en_at_last !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_timing: got en_cycles=%0d ready=%b en=%b want 4 1 0", obs_en_cyc,
               obs_ready_at_last, obs_en_at_last);
    end
  endtask

`ifdef MEM_CLIENT_BURST_EN
  task automatic test_burst();
    logic [9:0] ea[4];
    logic       eb[4];
    ea = '{10'h3F8, 10'h3FC, 10'h000, 10'h004};
    eb = '{1'b1, 1'b1, 1'b1, 1'b0};
    dly = '{0, 1, 2, 0};
    for (int b = 0; b < 4; b++) dat[b] = $urandom;
    txn_len = 2'd3;
    run_txn(1'b0, 10'h3F8, $urandom);
    n_vec++;
    if (obs_hung || obs_n != 4 || obs_nack != 4 || obs_unstable) begin
      n_err++;
      $display("FAIL burst_count: got n=%0d acks=%0d unstable=%0d want 4 4 0", obs_n, obs_nack,
               obs_unstable);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (obs_addr[i] !== ea[i] || obs_burst[i] !== eb[i] || obs_rdata[i] !== dat[i] ||
          obs_last[i] !== (i == 3)) begin
        n_err++;
        $display("FAIL burst_beat%0d: got addr=%h bu=%b rd=%h l=%b want %h %b %h %b", i,
                 obs_addr[i], obs_burst[i], obs_rdata[i], obs_last[i], ea[i], eb[i], dat[i],
                 (i == 3));
      end
    end
    run_txn(1'b1, 10'h3F8, 32'hCAFEF00D);
    n_vec++;
    if (obs_hung || obs_n != 1 || obs_burst[0] !== 1'b0 || obs_last[0] !== 1'b1) begin
      n_err++;
      $display("FAIL burst_write: got n=%0d bu=%b l=%b want 1 0 1", obs_n, obs_burst[0],
               obs_last[0]);
    end
  endtask
`endif

  task automatic test_random();
    logic we;
    logic [9:0] addr;
    logic [31:0] wd;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1)); addr = 10'($urandom); wd = $urandom;
      txn_len = 2'($urandom);
      for (int b = 0; b < 4; b++) begin
        dly[b] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(AckTo, AckTo + 3))
                                             : int'($urandom_range(0, AckTo - 1));
        dat[b] = $urandom;
      end
      model_txn(we, addr);
      run_txn(we, addr, wd);
      n_vec++;
      if (obs_hung || obs_n != exp_n || obs_nack != exp_nack) begin
        n_err++;
        $display("FAIL rand%0d_count: got rsp=%0d acks=%0d hung=%0d want %0d %0d", n, obs_n,
                 obs_nack, obs_hung, exp_n, exp_nack);
      end
      for (int i = 0; i < exp_n; i++) begin
        n_vec++;
        if ({obs_rdata[i], obs_last[i], obs_err[i]} !== {exp_rdata[i], exp_last[i], exp_err[i]})
        begin
          n_err++;
          $display("FAIL rand%0d_rsp%0d: got %h l=%b e=%b want %h l=%b e=%b", n, i, obs_rdata[i],
                   obs_last[i], obs_err[i], exp_rdata[i], exp_last[i], exp_err[i]);
        end
      end
      for (int i = 0; i < exp_nack; i++) begin
        n_vec++;
        if (obs_addr[i] !== exp_addr[i] || obs_we[i] !== we || obs_burst[i] !== exp_burst[i] ||
            (we && obs_di[i] !== wd)) begin
          n_err++;
          $display("FAIL rand%0d_req%0d: got a=%h we=%b bu=%b di=%h want %h %b %b %h", n, i,
                   obs_addr[i], obs_we[i], obs_burst[i], obs_di[i], exp_addr[i], we,
                   exp_burst[i], wd);
        end
      end
      n_vec++;
      if (obs_en_cyc != exp_en_cyc || obs_unstable ||
          {obs_ready_at_req, obs_ready_at_last, obs_en_at_last} !== 3'b110) begin
        n_err++;
        $display("FAIL rand%0d_ctrl: got en_cyc=%0d unstable=%0d rdy/rdy/en=%b%b%b want %0d 0 110",
                 n, obs_en_cyc, obs_unstable, obs_ready_at_req, obs_ready_at_last,
                 obs_en_at_last, exp_en_cyc);
      end
    end
  endtask

  // Reset in REQ: mem_en must fall without waiting for a clock, no response follows, and acks
  // arriving while idle are ignored.
  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'h055;
`ifdef MEM_CLIENT_BURST_EN
    bus.req_len = 2'd3;
`endif
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.mem_en !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: got en=%b want 1", bus.mem_en);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.mem_en !== 1'b0) begin
      n_err++; $display("FAIL rstmid_async: got en=%b want 0", bus.mem_en);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      bus.mem_do_ack = 1'($urandom_range(0, 1));
      bus.mem_do = $urandom;
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.req_ready !== 1'b1) bad++;
    end
    bus.mem_do_ack = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL rstmid_quiet: got %0d busy/rsp cycles want 0", bad);
    end
  endtask

  // req_valid held high with immediate acks: consecutive requests need a mem_en-low gap.
  task automatic test_back_to_back();
    logic [31:0] q[$];
    int n_ack = 0;
    int n_rsp = 0;
    int viol = 0;
    bit prev_ack = 1'b0;
    logic [31:0] want;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'h100;
`ifdef MEM_CLIENT_BURST_EN
    bus.req_len = 2'd0;
`endif
    for (int t = 0; t < 60 && n_rsp < 4; t++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        n_rsp++;
        want = (q.size() != 0) ? q[0] : 32'd0;
        n_vec++;
        if (q.size() == 0 || bus.rsp_rdata !== want || bus.rsp_last !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_rsp%0d: got %h l=%b want %h l=1", n_rsp, bus.rsp_rdata,
                   bus.rsp_last, want);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (prev_ack && bus.mem_en === 1'b1) viol++;
      prev_ack = 1'b0;
      if (bus.mem_en === 1'b1 && n_ack < 4) begin
        bus.mem_do_ack = 1'b1;
        bus.mem_do = $urandom;
        q.push_back(bus.mem_do);
        n_ack++;
        prev_ack = 1'b1;
        if (n_ack == 4) bus.req_valid = 1'b0;
      end else begin
        bus.mem_do_ack = 1'b0;
        bus.mem_do = $urandom;
      end
    end
    bus.mem_do_ack = 1'b0;
    bus.req_valid = 1'b0;
    n_vec++;
    if (n_rsp != 4 || viol != 0) begin
      n_err++;
      $display("FAIL b2b_gap: got rsp=%0d no-gap=%0d want 4 0", n_rsp, viol);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_timeout();
`ifdef MEM_CLIENT_BURST_EN
    test_burst();
`endif
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_client.md
MEM_CLIENT -- requirements
Module: mem_client

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, meaning: REQ-state cycles without ack before abort; 0 disables timeout.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 req_valid  in  1  local command valid.
REQ-005 req_ready  out  1  high when state is IDLE; command accepted on edge where req_valid and req_ready are both high.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  10  byte address.
REQ-008 req_wdata  in  32  write data.
REQ-009 req_len  in  2  beats minus 1; port exists only with MEM_CLIENT_BURST_EN.
REQ-010 rsp_valid  out  1  one-cycle pulse per completed beat or abort.
REQ-011 rsp_rdata  out  32  read data for the beat; 0 for writes and aborts.
REQ-012 rsp_last  out  1  high with rsp_valid on final beat or abort.
REQ-013 rsp_err  out  1  high with rsp_valid on timeout abort.
REQ-014 mem_en, mem_we, mem_burst_en  out  1 each  device-side request lines to the memory controller.
REQ-015 mem_addr  out  10; mem_di  out  32  registered request address and data.
REQ-016 mem_do_ack  in  1  this device's ack bit; mem_do  in  32  shared memory read data, valid in the ack cycle.

Function
REQ-017 States: IDLE, REQ; only these two; any other encoding returns to IDLE.
REQ-018 IDLE: on accept, capture addr/wdata/we/len into mem_addr/mem_di/mem_we, set mem_en=1, clear timeout counter, go to REQ.
REQ-019 REQ: mem_en, mem_addr, mem_di, mem_we held stable until ack sampled.
REQ-020 On ack edge: rsp_valid=1 next cycle, rsp_rdata = mem_do sampled at ack edge (reads) else 0.
REQ-021 On ack of last beat: mem_en=0, mem_we=0, mem_burst_en=0, rsp_last=1, go to IDLE; req_ready high in same cycle as rsp_valid.
REQ-022 Minimum one cycle with mem_en low between consecutive transactions.
REQ-023 Timeout counter (8 bits) increments each REQ cycle without ack; on reaching ACK_TIMEOUT: mem_en=0, rsp_valid=1, rsp_err=1, rsp_last=1, rsp_rdata=0, go to IDLE.
REQ-024 Ack and timeout in same cycle: ack wins, rsp_err=0.
REQ-025 Ack while IDLE ignored; req_valid while not ready ignored, no state change.
REQ-026 Counter cleared on every ack.

Reset
REQ-027 Reset forces IDLE; mem_en, mem_we, mem_burst_en, rsp_valid, rsp_last, rsp_err = 0; mem_addr, mem_di, rsp_rdata = 0; req_ready = 1.
REQ-028 Reset mid-transaction: mem_en drops asynchronously, no rsp_valid issued for the aborted transaction.

Configuration
REQ-029 Macro MEM_CLIENT_BURST_EN: when defined, req_len port exists; reads run req_len+1 beats; mem_burst_en=1 while more than one beat remains; mem_addr += 4 on each non-final ack, wrapping modulo 1024; mem_en stays high between beats; rsp_valid per beat, rsp_last on final.
REQ-030 With burst: writes ignore req_len and run one beat.
REQ-031 Without macro: no req_len port, mem_burst_en tied 0, every transaction one beat.

Verification
REQ-032 Single read addr 0x010, ack after 3 cycles, mem_do=0xDEADBEEF -> one rsp_valid, rdata 0xDEADBEEF, rsp_last=1, mem_en low next cycle.
REQ-033 Single write addr 0x020 data 0x12345678, ack after 1 cycle -> mem_we=1 and mem_di=0x12345678 until ack; rsp_valid, rdata 0.
REQ-034 ACK_TIMEOUT=4, never ack -> rsp_valid with rsp_err=1 four cycles after mem_en rises; req_ready returns 1.
REQ-035 Burst (macro on) read len=3 addr 0x3F8 -> addresses 0x3F8, 0x3FC, 0x000, 0x004; four rsp_valid, rsp_last on fourth; mem_burst_en low on fourth beat.
REQ-036 Reset asserted while in REQ -> mem_en 0 immediately, no rsp_valid; back-to-back reads after reset separated by at least one mem_en-low cycle.
